// File: rtl/nfc_seq_pkg.sv
// nfc_seq_pkg: shared definitions for the NAND operation sequencer.
//   - operation codes accepted on seq_op
//   - NAND command bytes issued through nfc_if
//   - sequencer FSM state encoding
//   - per-op step table (get_step) used to walk each operation
// Optional feature macro: NFC_SEQ_STATUS_CHK_EN appends a status read
// (70h + 1-byte read) to PROGRAM and ERASE.
package nfc_seq_pkg;

  localparam logic [2:0] OP_RD_STATUS = 3'd0;
  localparam logic [2:0] OP_PAGE_READ = 3'd1;
  localparam logic [2:0] OP_PROGRAM   = 3'd2;
  localparam logic [2:0] OP_ERASE     = 3'd3;
  localparam logic [2:0] OP_READ_ID   = 3'd4;

  localparam logic [7:0] CMD_READ1  = 8'h00;
  localparam logic [7:0] CMD_READ2  = 8'h30;
  localparam logic [7:0] CMD_PROG1  = 8'h80;
  localparam logic [7:0] CMD_PROG2  = 8'h10;
  localparam logic [7:0] CMD_ERASE1 = 8'h60;
  localparam logic [7:0] CMD_ERASE2 = 8'hD0;
  localparam logic [7:0] CMD_STATUS = 8'h70;
  localparam logic [7:0] CMD_READID = 8'h90;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_CMD_W, S_ADDR, S_ADDR_W,
    S_DATA, S_DATA_W, S_RB_BLANK, S_RB_WAIT, S_DONE
  } state_e;

  typedef enum logic [2:0] {STP_END, STP_CMD, STP_ADDR, STP_DATA, STP_RB} stp_e;

  // One entry of an operation's step list.
  //   wr   : data step direction (1 = write to flash)
  //   stat : data step is a 1-byte status read (captured into seq_status)
  typedef struct packed {
    stp_e       kind;
    logic [7:0] cmd;
    logic       wr;
    logic       stat;
  } step_t;

  function automatic step_t stp(stp_e k, logic [7:0] c, logic w, logic s);
    step_t r;
    r.kind = k;
    r.cmd  = c;
    r.wr   = w;
    r.stat = s;
    return r;
  endfunction

  function automatic logic op_legal(logic [2:0] op);
    return op <= OP_READ_ID;
  endfunction

  // Step idx of operation op; anything past the end of a list is STP_END.
  function automatic step_t get_step(logic [2:0] op, logic [2:0] idx);
    step_t s;
    s = stp(STP_END, 8'h00, 1'b0, 1'b0);
    case (op)
      OP_RD_STATUS: case (idx)
        3'd0: s = stp(STP_CMD,  CMD_STATUS, 1'b0, 1'b0);
        3'd1: s = stp(STP_DATA, 8'h00,      1'b0, 1'b1);
        default: ;
      endcase
      OP_PAGE_READ: case (idx)
        3'd0: s = stp(STP_CMD,  CMD_READ1, 1'b0, 1'b0);
        3'd1: s = stp(STP_ADDR, 8'h00,     1'b0, 1'b0);
        3'd2: s = stp(STP_CMD,  CMD_READ2, 1'b0, 1'b0);
        3'd3: s = stp(STP_RB,   8'h00,     1'b0, 1'b0);
        3'd4: s = stp(STP_DATA, 8'h00,     1'b0, 1'b0);
        default: ;
      endcase
      OP_PROGRAM: case (idx)
        3'd0: s = stp(STP_CMD,  CMD_PROG1, 1'b0, 1'b0);
        3'd1: s = stp(STP_ADDR, 8'h00,     1'b0, 1'b0);
        3'd2: s = stp(STP_DATA, 8'h00,     1'b1, 1'b0);
        3'd3: s = stp(STP_CMD,  CMD_PROG2, 1'b0, 1'b0);
        3'd4: s = stp(STP_RB,   8'h00,     1'b0, 1'b0);
`ifdef NFC_SEQ_STATUS_CHK_EN
        3'd5: s = stp(STP_CMD,  CMD_STATUS, 1'b0, 1'b0);
        3'd6: s = stp(STP_DATA, 8'h00,      1'b0, 1'b1);
`endif
        default: ;
      endcase
      OP_ERASE: case (idx)
        3'd0: s = stp(STP_CMD,  CMD_ERASE1, 1'b0, 1'b0);
        3'd1: s = stp(STP_ADDR, 8'h00,      1'b0, 1'b0);
        3'd2: s = stp(STP_CMD,  CMD_ERASE2, 1'b0, 1'b0);
        3'd3: s = stp(STP_RB,   8'h00,      1'b0, 1'b0);
`ifdef NFC_SEQ_STATUS_CHK_EN
        3'd4: s = stp(STP_CMD,  CMD_STATUS, 1'b0, 1'b0);
        3'd5: s = stp(STP_DATA, 8'h00,      1'b0, 1'b1);
`endif
        default: ;
      endcase
      OP_READ_ID: case (idx)
        3'd0: s = stp(STP_CMD,  CMD_READID, 1'b0, 1'b0);
        3'd1: s = stp(STP_ADDR, 8'h00,      1'b0, 1'b0);
        3'd2: s = stp(STP_DATA, 8'h00,      1'b0, 1'b0);
        default: ;
      endcase
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nfc_seq_rb_mon.sv
// nfc_rb_mon: R/B# monitor for the sequencer.
//   clk, rst  : clock, async active-high reset
//   nf_rb     : raw R/B# from the pad (0 = busy)
//   rb_arm    : one-cycle pulse, starts a new wait (blank window + timeout)
//   rb_ready  : blank window over and synchronised R/B# high
//   rb_tout   : timeout counter saturated (2^RB_TOUT_W-1 cycles after blank)
module nfc_rb_mon #(
  parameter int RB_BLANK  = 16,
  parameter int RB_TOUT_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic nf_rb,
  input  logic rb_arm,
  output logic rb_ready,
  output logic rb_tout
);

  localparam int BLANK_W = (RB_BLANK < 2) ? 1 : $clog2(RB_BLANK + 1);

  logic [1:0]           sync_q;
  logic [BLANK_W-1:0]   blank_q;
  logic [RB_TOUT_W-1:0] tout_q;
  logic                 blank_done;

  assign blank_done = (blank_q == '0);
  assign rb_tout    = &tout_q;
  assign rb_ready   = blank_done && sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      blank_q <= '0;
      tout_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], nf_rb};
      if (rb_arm) begin
        blank_q <= BLANK_W'(RB_BLANK);
        tout_q  <= '0;
      end else begin
        if (!blank_done) blank_q <= blank_q - 1'b1;
        // timeout only runs once the tWB blank window has elapsed
        if (blank_done && !rb_tout) tout_q <= tout_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nfc_seq.sv
// nfc_seq: NAND operation sequencer feeding nfc_if.
// Expands one host operation (RD_STATUS, PAGE_READ, PROGRAM, ERASE,
// READ_ID) into ordered cmd / addr / data step requests, waiting on each
// nfif_*_done pulse and on R/B# between steps.
// Ports:
//   host side : seq_start, seq_op, seq_col_addr, seq_row_addr, seq_addr_cnt,
//               seq_dat_cnt -> seq_busy, seq_done, seq_err, seq_status
//   pad       : nf_rb (raw R/B#)
//   nfc_if    : nfc_cmd_en/addr_en/dat_en + step fields out,
//               nfif_*_done, nfif_data_wr, nfif_data_out in
// Optional feature macro: NFC_SEQ_STATUS_CHK_EN (status check after
// PROGRAM / ERASE; step list lives in nfc_seq_pkg::get_step).
module nfc_seq
  import nfc_seq_pkg::*;
#(
  parameter int DAT_WID   = 8,
  parameter int SFR_WID   = 8,
  parameter int RB_BLANK  = 16,
  parameter int RB_TOUT_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seq_start,
  input  logic [2:0]         seq_op,
  input  logic [31:0]        seq_col_addr,
  input  logic [31:0]        seq_row_addr,
  input  logic [5:0]         seq_addr_cnt,
  input  logic [13:0]        seq_dat_cnt,
  output logic               seq_busy,
  output logic               seq_done,
  output logic [2:0]         seq_err,
  output logic [7:0]         seq_status,
  input  logic               nf_rb,
  output logic               nfc_cmd_en,
  output logic               nfc_addr_en,
  output logic               nfc_dat_en,
  output logic [SFR_WID-1:0] nfc_if_cmd,
  output logic [31:0]        nfc_col_addr,
  output logic [31:0]        nfc_row_addr,
  output logic [5:0]         nfc_addr_cnt,
  output logic [13:0]        nfc_dat_cnt,
  output logic               nfc_dat_dir,
  input  logic               nfif_cmd_done,
  input  logic               nfif_addr_done,
  input  logic               nfif_dat_done,
  input  logic               nfif_data_wr,
  input  logic [DAT_WID-1:0] nfif_data_out
);

  state_e             state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        col_q, col_d, row_q, row_d;
  logic [5:0]         acnt_q, acnt_d;
  logic [13:0]        dcnt_q, dcnt_d;
  logic [2:0]         err_q, err_d;
  logic [7:0]         status_q, status_d;
  logic               stat_rd_q, stat_rd_d;
  logic [SFR_WID-1:0] ncmd_q, ncmd_d;
  logic [31:0]        ncol_q, ncol_d, nrow_q, nrow_d;
  logic [5:0]         nacnt_q, nacnt_d;
  logic [13:0]        ndcnt_q, ndcnt_d;
  logic               ndir_q, ndir_d;

  logic [2:0] lk_op, lk_idx;
  step_t      nxt;
  logic       adv;
  logic       rb_ready, rb_tout;

  // Step lookup: in IDLE the first step of the incoming op, otherwise the
  // step after the one currently in flight.
  assign lk_op  = (state_q == S_IDLE) ? seq_op : op_q;
  assign lk_idx = (state_q == S_IDLE) ? 3'd0 : step_q + 3'd1;

  // RB_BLANK is a single arming cycle; the blank window itself is counted
  // inside the monitor while the FSM sits in RB_WAIT.
  nfc_rb_mon #(
    .RB_BLANK  (RB_BLANK),
    .RB_TOUT_W (RB_TOUT_W)
  ) u_rb_mon (
    .clk      (clk),
    .rst      (rst),
    .nf_rb    (nf_rb),
    .rb_arm   (state_q == S_RB_BLANK),
    .rb_ready (rb_ready),
    .rb_tout  (rb_tout)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    op_d      = op_q;
    col_d     = col_q;
    row_d     = row_q;
    acnt_d    = acnt_q;
    dcnt_d    = dcnt_q;
    err_d     = err_q;
    status_d  = status_q;
    stat_rd_d = stat_rd_q;
    ncmd_d    = ncmd_q;
    ncol_d    = ncol_q;
    nrow_d    = nrow_q;
    nacnt_d   = nacnt_q;
    ndcnt_d   = ndcnt_q;
    ndir_d    = ndir_q;
    nxt       = get_step(lk_op, lk_idx);
    adv       = 1'b0;

    case (state_q)
      S_IDLE: if (seq_start) begin
        op_d   = seq_op;
        col_d  = seq_col_addr;
        row_d  = seq_row_addr;
        acnt_d = seq_addr_cnt;
        dcnt_d = seq_dat_cnt;
        step_d = 3'd0;
        err_d  = 3'b000;
        if (!op_legal(seq_op)) begin
          err_d   = 3'b100;
          state_d = S_DONE;
        end else begin
          adv = 1'b1;
        end
      end
      S_CMD:    state_d = S_CMD_W;
      S_CMD_W:  if (nfif_cmd_done) adv = 1'b1;
      S_ADDR:   state_d = S_ADDR_W;
      S_ADDR_W: if (nfif_addr_done) adv = 1'b1;
      S_DATA:   state_d = S_DATA_W;
      S_DATA_W: begin
        if (stat_rd_q && nfif_data_wr) begin
          status_d = nfif_data_out[7:0];
          if (nfif_data_out[0]) err_d[0] = 1'b1;
        end
        if (nfif_dat_done) adv = 1'b1;
      end
      S_RB_BLANK: state_d = S_RB_WAIT;
      S_RB_WAIT: begin
        if (rb_ready) begin
          adv = 1'b1;
        end else if (rb_tout) begin
          err_d[1] = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (state_q != S_IDLE) step_d = step_q + 3'd1;
      case (nxt.kind)
        STP_CMD: begin
          state_d = S_CMD;
          ncmd_d  = SFR_WID'(nxt.cmd);
        end
        STP_ADDR: begin
          state_d = S_ADDR;
          ncol_d  = col_q;
          nrow_d  = row_q;
          nacnt_d = acnt_q;
          if (op_q == OP_ERASE) nacnt_d = {acnt_q[5:3], 3'b000};
          if (op_q == OP_READ_ID) begin
            ncol_d  = 32'd0;
            nacnt_d = 6'b000_001;
          end
        end
        STP_DATA: begin
          state_d   = S_DATA;
          ndcnt_d   = nxt.stat ? 14'd1 : dcnt_q;
          ndir_d    = nxt.wr;
          stat_rd_d = nxt.stat;
        end
        STP_RB:  state_d = S_RB_BLANK;
        default: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= 3'd0;
      op_q      <= 3'd0;
      col_q     <= 32'd0;
      row_q     <= 32'd0;
      acnt_q    <= 6'd0;
      dcnt_q    <= 14'd0;
      err_q     <= 3'b000;
      status_q  <= 8'h00;
      stat_rd_q <= 1'b0;
      ncmd_q    <= '0;
      ncol_q    <= 32'd0;
      nrow_q    <= 32'd0;
      nacnt_q   <= 6'd0;
      ndcnt_q   <= 14'd0;
      ndir_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      op_q      <= op_d;
      col_q     <= col_d;
      row_q     <= row_d;
      acnt_q    <= acnt_d;
      dcnt_q    <= dcnt_d;
      err_q     <= err_d;
      status_q  <= status_d;
      stat_rd_q <= stat_rd_d;
      ncmd_q    <= ncmd_d;
      ncol_q    <= ncol_d;
      nrow_q    <= nrow_d;
      nacnt_q   <= nacnt_d;
      ndcnt_q   <= ndcnt_d;
      ndir_q    <= ndir_d;
    end
  end

  assign seq_busy     = (state_q != S_IDLE);
  assign seq_done     = (state_q == S_DONE);
  assign seq_err      = err_q;
  assign seq_status   = status_q;
  assign nfc_cmd_en   = (state_q == S_CMD);
  assign nfc_addr_en  = (state_q == S_ADDR);
  assign nfc_dat_en   = (state_q == S_DATA);
  assign nfc_if_cmd   = ncmd_q;
  assign nfc_col_addr = ncol_q;
  assign nfc_row_addr = nrow_q;
  assign nfc_addr_cnt = nacnt_q;
  assign nfc_dat_cnt  = ndcnt_q;
  assign nfc_dat_dir  = ndir_q;

endmodule
